// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Fully associative branch target buffer with one 2-bit saturating direction
//   counter per entry. Fetch looks up f_pc combinationally; execute reports each
//   resolved branch, which trains the counter, refreshes the target on taken
//   hits and allocates a new entry on taken misses.
//
//   Optional build macro: BTB_BYPASS_EN
//     When defined, a fetch lookup whose PC equals the PC being updated by
//     execute in the same cycle sees the post-update entry state. When
//     undefined, fetch always sees registered state and there is no x_* -> f_*
//     path.
//
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset
//   f_pc             fetch PC to predict for
//   f_predict_addr   predicted target, 0 on miss
//   f_predict_valid  hit and counter predicts taken
//   f_hit            f_pc present in a valid entry
//   x_valid          execute reports a resolved branch this cycle
//   x_pc             PC of the resolved branch
//   x_taken          branch outcome
//   x_target         actual target of the resolved branch
//   x_mispredict     registered; high one cycle after a mispredicted x_valid
module branch_target_buffer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  output logic              f_hit,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target,
  output logic              x_mispredict
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CntReset = 2'b01;
  localparam logic [1:0] CntAlloc = 2'b10;

  // Table state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [IDX_W-1:0]   repl_ptr_q, repl_ptr_d;
  logic               mispredict_q, mispredict_d;

  // Execute-side lookup and victim selection
  logic             x_hit;
  logic [IDX_W-1:0] x_idx;
  logic             inv_found;
  logic [IDX_W-1:0] inv_idx;
  logic             x_pred_taken;

  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

  always_comb begin
    x_hit     = 1'b0;
    x_idx     = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    // Lowest index wins on both searches.
    for (int i = 0; i < ENTRIES; i++) begin
      if (!x_hit && valid_q[i] && (tag_q[i] == x_pc)) begin
        x_hit = 1'b1;
        x_idx = IDX_W'(i);
      end
      if (!inv_found && !valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign x_pred_taken = x_hit && cnt_q[x_idx][1];

  // Next-state for the table
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    repl_ptr_d   = repl_ptr_q;
    mispredict_d = 1'b0;

    if (x_valid) begin
      mispredict_d = (x_pred_taken != x_taken);
      if (x_hit) begin
        cnt_d[x_idx] = cnt_train(cnt_q[x_idx], x_taken);
        if (x_taken) begin
          target_d[x_idx] = x_target;
        end
      end else if (x_taken) begin
        if (inv_found) begin
          valid_d[inv_idx]  = 1'b1;
          tag_d[inv_idx]    = x_pc;
          target_d[inv_idx] = x_target;
          cnt_d[inv_idx]    = CntAlloc;
        end else begin
          valid_d[repl_ptr_q]  = 1'b1;
          tag_d[repl_ptr_q]    = x_pc;
          target_d[repl_ptr_q] = x_target;
          cnt_d[repl_ptr_q]    = CntAlloc;
          // Explicit wrap so non-power-of-two table sizes cycle correctly.
          repl_ptr_d = (repl_ptr_q == LastIdx) ? '0 : repl_ptr_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= '0;
      repl_ptr_q   <= '0;
      mispredict_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CntReset;
      end
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      repl_ptr_q   <= repl_ptr_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign x_mispredict = mispredict_q;

  // Fetch-side view of the table
  logic [ENTRIES-1:0] fv_valid;
  logic [ADDR_W-1:0]  fv_tag    [ENTRIES];
  logic [ADDR_W-1:0]  fv_target [ENTRIES];
  logic [1:0]         fv_cnt    [ENTRIES];

`ifdef BTB_BYPASS_EN
  logic bypass;
  assign bypass = rst_n && x_valid && (x_pc == f_pc);

  always_comb begin
    if (bypass) begin
      fv_valid  = valid_d;
      fv_tag    = tag_d;
      fv_target = target_d;
      fv_cnt    = cnt_d;
    end else begin
      fv_valid  = valid_q;
      fv_tag    = tag_q;
      fv_target = target_q;
      fv_cnt    = cnt_q;
    end
  end
`else
  always_comb begin
    fv_valid  = valid_q;
    fv_tag    = tag_q;
    fv_target = target_q;
    fv_cnt    = cnt_q;
  end
`endif

  logic [IDX_W-1:0] f_idx;

  always_comb begin
    f_hit = 1'b0;
    f_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!f_hit && fv_valid[i] && (fv_tag[i] == f_pc)) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
    end
  end

  assign f_predict_valid = f_hit && fv_cnt[f_idx][1];
  assign f_predict_addr  = f_hit ? fv_target[f_idx] : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  localparam int unsigned AW = 32;
  localparam int unsigned NE = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] f_pc;
  logic [AW-1:0] f_predict_addr;
  logic          f_predict_valid;
  logic          f_hit;
  logic          x_valid;
  logic [AW-1:0] x_pc;
  logic          x_taken;
  logic [AW-1:0] x_target;
  logic          x_mispredict;

  branch_target_buffer #(.ADDR_W(AW), .ENTRIES(NE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .f_pc            (f_pc),
    .f_predict_addr  (f_predict_addr),
    .f_predict_valid (f_predict_valid),
    .f_hit           (f_hit),
    .x_valid         (x_valid),
    .x_pc            (x_pc),
    .x_taken         (x_taken),
    .x_target        (x_target),
    .x_mispredict    (x_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Behavioural model: a list of entries with integer counters 0..3.
  bit          m_valid  [NE];
  logic [31:0] m_tag    [NE];
  logic [31:0] m_target [NE];
  int          m_cnt    [NE];
  int          m_ptr;
  bit          exp_mis;

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < NE; i++) if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
    end
    m_ptr = 0;
  endtask

  task automatic m_apply(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    int idx;
    int v;
    idx = m_find(pc);
    if (idx >= 0) begin
      if (tk) begin
        m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
        m_target[idx] = tg;
      end else begin
        m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
      end
    end else if (tk) begin
      v = -1;
      for (int i = 0; i < NE; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % NE;
      end
      m_valid[v] = 1; m_tag[v] = pc; m_target[v] = tg; m_cnt[v] = 2;
    end
  endtask

  initial begin
    m_clear();
    exp_mis = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_clear();
        exp_mis = 0;
      end else if (x_valid) begin
        int idx;
        bit pred;
        idx = m_find(x_pc);
        pred = (idx >= 0) && (m_cnt[idx] >= 2);
        exp_mis = (pred != x_taken);
        m_apply(x_pc, x_taken, x_target);
      end else begin
        exp_mis = 0;
      end
    end
  end

  task automatic m_fetch(output bit hit, output bit pv, output logic [31:0] addr);
    int idx;
`ifdef BTB_BYPASS_EN
    bit          sv_valid  [NE];
    logic [31:0] sv_tag    [NE];
    logic [31:0] sv_target [NE];
    int          sv_cnt    [NE];
    int          sv_ptr;
    bit          byp;
    byp = rst_n && x_valid && (x_pc == f_pc);
    sv_valid = m_valid; sv_tag = m_tag; sv_target = m_target; sv_cnt = m_cnt;
    sv_ptr = m_ptr;
    if (byp) m_apply(x_pc, x_taken, x_target);
`endif
    idx  = m_find(f_pc);
    hit  = (idx >= 0);
    pv   = hit && (m_cnt[idx] >= 2);
    addr = hit ? m_target[idx] : 32'h0;
`ifdef BTB_BYPASS_EN
    m_valid = sv_valid; m_tag = sv_tag; m_target = sv_target; m_cnt = sv_cnt;
    m_ptr = sv_ptr;
`endif
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        bit e_hit;
        bit e_pv;
        logic [31:0] e_addr;
        m_fetch(e_hit, e_pv, e_addr);
        checks++;
        if (f_hit !== e_hit || f_predict_valid !== e_pv || f_predict_addr !== e_addr ||
            x_mispredict !== exp_mis) begin
          errors++;
          $display("FAIL model t=%0t f_pc=%h: got hit=%b pv=%b addr=%h mis=%b, required hit=%b pv=%b addr=%h mis=%b",
                   $time, f_pc, f_hit, f_predict_valid, f_predict_addr, x_mispredict,
                   e_hit, e_pv, e_addr, exp_mis);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the posedge, then wait for the negedge.
  task automatic go(input bit xv, input logic [31:0] pc, input bit tk,
                    input logic [31:0] tg, input logic [31:0] fpc);
    @(posedge clk);
    #1;
    x_valid = xv; x_pc = pc; x_taken = tk; x_target = tg; f_pc = fpc;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] fpc);
    go(0, 32'h0, 0, 32'h0, fpc);
  endtask

  task automatic alloc(input logic [31:0] pc);
    go(1, pc, 1, pc + 32'h1000, 32'h0);
  endtask

  initial begin
    rst_n = 0; x_valid = 0; x_pc = 0; x_taken = 0; x_target = 0; f_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    checking = 1;
    @(negedge clk);
    lit("reset_hit", {31'b0, f_hit}, 32'd0);
    lit("reset_pv", {31'b0, f_predict_valid}, 32'd0);
    lit("reset_addr", f_predict_addr, 32'h0);
    lit("reset_mis", {31'b0, x_mispredict}, 32'd0);

    // First allocation with same-cycle lookup.
    go(1, 32'h100, 1, 32'h200, 32'h100);
`ifdef BTB_BYPASS_EN
    lit("same_cycle_hit", {31'b0, f_hit}, 32'd1);
`else
    lit("same_cycle_hit", {31'b0, f_hit}, 32'd0);
`endif
    idle(32'h100);
    lit("alloc_hit", {31'b0, f_hit}, 32'd1);
    lit("alloc_pv", {31'b0, f_predict_valid}, 32'd1);
    lit("alloc_addr", f_predict_addr, 32'h200);
    lit("alloc_mis", {31'b0, x_mispredict}, 32'd1);

    // Train not-taken three times: 10 -> 01 -> 00 -> 00.
    repeat (3) go(1, 32'h100, 0, 32'h0, 32'h100);
    idle(32'h100);
    lit("nt_pv", {31'b0, f_predict_valid}, 32'd0);
    lit("nt_hit", {31'b0, f_hit}, 32'd1);
    go(1, 32'h100, 1, 32'h200, 32'h100);
    idle(32'h100);
    lit("t1_pv", {31'b0, f_predict_valid}, 32'd0);
    go(1, 32'h100, 1, 32'h200, 32'h100);
    idle(32'h100);
    lit("t2_pv", {31'b0, f_predict_valid}, 32'd1);
    lit("t2_mis", {31'b0, x_mispredict}, 32'd1);

    // Taken hit refreshes target.
    go(1, 32'h100, 1, 32'h300, 32'h100);
    idle(32'h100);
    lit("refresh_addr", f_predict_addr, 32'h300);

    // Fill and replace; entry 0 holds 0x100.
    alloc(32'h10); alloc(32'h20); alloc(32'h30);
    alloc(32'h40);
    idle(32'h100);
    lit("repl0_old", {31'b0, f_hit}, 32'd0);
    idle(32'h10);
    lit("repl0_keep", {31'b0, f_hit}, 32'd1);
    alloc(32'h50);
    idle(32'h10);
    lit("repl1_old", {31'b0, f_hit}, 32'd0);
    go(1, 32'h700, 0, 32'h0, 32'h700);
    idle(32'h700);
    lit("nt_miss_noalloc", {31'b0, f_hit}, 32'd0);
    alloc(32'h60);
    idle(32'h20);
    lit("repl2_old", {31'b0, f_hit}, 32'd0);
    idle(32'h30);
    lit("repl2_keep", {31'b0, f_hit}, 32'd1);

    // Reset mid-stream with a coincident update.
    @(posedge clk);
    #1;
    rst_n = 0; x_valid = 1; x_pc = 32'h30; x_taken = 1; x_target = 32'h999; f_pc = 32'h30;
    @(posedge clk);
    #1;
    rst_n = 1; x_valid = 0;
    @(negedge clk);
    lit("rst_mid_hit", {31'b0, f_hit}, 32'd0);
    lit("rst_mid_mis", {31'b0, x_mispredict}, 32'd0);
    idle(32'h40);
    lit("rst_mid_hit2", {31'b0, f_hit}, 32'd0);

    // Replacement pointer restarts at 0 after reset.
    alloc(32'hA0); alloc(32'hB0); alloc(32'hC0); alloc(32'hD0);
    alloc(32'hE0);
    idle(32'hA0);
    lit("ptr_restart_old", {31'b0, f_hit}, 32'd0);
    idle(32'hD0);
    lit("ptr_restart_keep", {31'b0, f_hit}, 32'd1);
    alloc(32'hF0); alloc(32'h110); alloc(32'h120); alloc(32'h130);
    idle(32'hE0);
    lit("wrap_old", {31'b0, f_hit}, 32'd0);
    idle(32'hF0);
    lit("wrap_keep", {31'b0, f_hit}, 32'd1);
    lit("wrap_addr", f_predict_addr, 32'h10F0);
    idle(32'h0);

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
